// File: rtl/sampler_mode.sv
// sampler_mode: stream sampler between the input synchronizer and the
// trigger/FIFO chain. Selects bypass, divide-by-N decimation or masked
// change-only capture at run time. Counts post-trigger beats and flags the
// final one on sto_tlast. Registered output stage with valid/ready on both sides.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   ctl_st1 / ctl_st0        start / stop pulses (stop wins)
//   cfg_mod/div/num/msk      mode, decimation divider, post-trigger count, change mask
//   sts_run                  high while armed or counting post-trigger beats
//   sti_*                    input stream (tdata, tvalid, trigger, tready)
//   sto_*                    output stream (tdata, tvalid, trigger, tlast, tready)
//   sts_cnt                  beats emitted since last start (SAMPLER_MODE_STS_EN only)
//
// Build option: define SAMPLER_MODE_STS_EN to add the sts_cnt output and counter.

module sampler_mode #(
  parameter int unsigned SDW = 32,
  parameter int unsigned SCW = 32,
  parameter int unsigned SNW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ctl_st1,
  input  logic           ctl_st0,
  input  logic [1:0]     cfg_mod,
  input  logic [SCW-1:0] cfg_div,
  input  logic [SNW-1:0] cfg_num,
  input  logic [SDW-1:0] cfg_msk,
  output logic           sts_run,
`ifdef SAMPLER_MODE_STS_EN
  output logic [SNW-1:0] sts_cnt,
`endif
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sti_tvalid,
  input  logic           sti_trigger,
  output logic           sti_tready,
  output logic [SDW-1:0] sto_tdata,
  output logic           sto_tvalid,
  output logic           sto_trigger,
  output logic           sto_tlast,
  input  logic           sto_tready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    POST = 2'd2
  } state_t;

  localparam logic [1:0] MOD_DEC = 2'd1;
  localparam logic [1:0] MOD_CHG = 2'd2;

  state_t         state, state_nxt;
  logic [SCW-1:0] div_cnt, div_nxt;
  logic [SNW-1:0] num_cnt, num_nxt;
  logic [SDW-1:0] chg_ref, chg_ref_nxt;
  logic           chg_first, chg_first_nxt;
  logic           run_nxt;
  logic [SDW-1:0] tdata_nxt;
  logic           tvalid_nxt, trigger_nxt, tlast_nxt;
`ifdef SAMPLER_MODE_STS_EN
  logic [SNW-1:0] emit_cnt, emit_nxt;
`endif

  logic           running_c;
  logic           last_pending_c;
  logic           in_acc_c;
  logic           out_acc_c;
  logic           chg_hit_c;
  logic           keep_mode_c;
  logic           keep_c;
  logic [SCW-1:0] div_base_c;
  logic [SCW-1:0] div_step_c;
  logic [SNW-1:0] num_inc_c;

  // Handshake qualification. Once the final post-trigger beat sits in the
  // output register no further input is taken until it drains.
  assign running_c      = (state != IDLE);
  assign last_pending_c = sto_tvalid & sto_tlast;
  assign sti_tready     = ~running_c | ((~sto_tvalid | sto_tready) & ~last_pending_c);
  assign in_acc_c       = running_c & sti_tvalid & sti_tready;
  assign out_acc_c      = sto_tvalid & sto_tready;

  // Per-mode keep decision; reserved mode 3 behaves as bypass.
  assign chg_hit_c = |((sti_tdata ^ chg_ref) & cfg_msk);

  always_comb begin
    keep_mode_c = 1'b1;
    case (cfg_mod)
      MOD_DEC: keep_mode_c = (div_cnt == '0);
      MOD_CHG: keep_mode_c = chg_first | chg_hit_c;
      default: keep_mode_c = 1'b1;
    endcase
  end

  assign keep_c = in_acc_c & (sti_trigger | keep_mode_c);

  // A trigger restarts the decimation phase as if it landed on slot 0.
  assign div_base_c = sti_trigger ? '0 : div_cnt;
  assign div_step_c = (div_base_c == cfg_div) ? '0 : div_base_c + SCW'(1);
  assign num_inc_c  = num_cnt + SNW'(1);

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    div_nxt       = div_cnt;
    num_nxt       = num_cnt;
    chg_ref_nxt   = chg_ref;
    chg_first_nxt = chg_first;
    tdata_nxt     = sto_tdata;
    tvalid_nxt    = sto_tvalid;
    trigger_nxt   = sto_trigger;
    tlast_nxt     = sto_tlast;
`ifdef SAMPLER_MODE_STS_EN
    emit_nxt      = emit_cnt;
`endif

    if (out_acc_c) begin
      tvalid_nxt  = 1'b0;
      trigger_nxt = 1'b0;
      tlast_nxt   = 1'b0;
    end

    if (in_acc_c) begin
      div_nxt = div_step_c;
    end

    if (keep_c) begin
      chg_ref_nxt   = sti_tdata;
      chg_first_nxt = 1'b0;
      tdata_nxt     = sti_tdata;
      tvalid_nxt    = 1'b1;
      trigger_nxt   = sti_trigger;
      tlast_nxt     = 1'b0;
`ifdef SAMPLER_MODE_STS_EN
      emit_nxt      = emit_cnt + SNW'(1);
`endif
    end

    case (state)
      IDLE: begin
        if (ctl_st1 && !ctl_st0) begin
          state_nxt     = ARM;
          div_nxt       = '0;
          num_nxt       = '0;
          chg_ref_nxt   = '0;
          chg_first_nxt = 1'b1;
`ifdef SAMPLER_MODE_STS_EN
          emit_nxt      = '0;
`endif
        end
      end
      ARM: begin
        // The trigger beat itself is post-trigger beat 1.
        if (keep_c && sti_trigger && (cfg_num != '0)) begin
          state_nxt = POST;
          num_nxt   = SNW'(1);
          tlast_nxt = (cfg_num == SNW'(1));
        end
      end
      POST: begin
        if (keep_c) begin
          num_nxt   = num_inc_c;
          tlast_nxt = (num_inc_c == cfg_num);
        end
        if (out_acc_c && sto_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (ctl_st0) begin
      state_nxt = IDLE;
    end

    run_nxt = (state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      num_cnt     <= '0;
      chg_ref     <= '0;
      chg_first   <= 1'b0;
      sts_run     <= 1'b0;
      sto_tdata   <= '0;
      sto_tvalid  <= 1'b0;
      sto_trigger <= 1'b0;
      sto_tlast   <= 1'b0;
`ifdef SAMPLER_MODE_STS_EN
      emit_cnt    <= '0;
`endif
    end else begin
      state       <= state_nxt;
      div_cnt     <= div_nxt;
      num_cnt     <= num_nxt;
      chg_ref     <= chg_ref_nxt;
      chg_first   <= chg_first_nxt;
      sts_run     <= run_nxt;
      sto_tdata   <= tdata_nxt;
      sto_tvalid  <= tvalid_nxt;
      sto_trigger <= trigger_nxt;
      sto_tlast   <= tlast_nxt;
`ifdef SAMPLER_MODE_STS_EN
      emit_cnt    <= emit_nxt;
`endif
    end
  end

`ifdef SAMPLER_MODE_STS_EN
  assign sts_cnt = emit_cnt;
`endif

endmodule
